// File: rtl/vram_write_scheduler_pkg.sv
// Shared GPU memory-map constants, write request payload and fill engine state encoding.
package vram_write_scheduler_pkg;

  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned TILE_AW  = 11;
  localparam int unsigned ATTR_AW  = 12;
  localparam int unsigned COLOR_AW = 4;

  localparam logic [ADDR_W-1:0] TILE_BASE  = 16'h0000;
  localparam logic [ADDR_W-1:0] ATTR_BASE  = 16'h0800;
  localparam logic [ADDR_W-1:0] COLOR_BASE = 16'h1800;

  typedef enum logic [1:0] {
    FILL_IDLE = 2'd0,
    FILL_RUN  = 2'd1,
    FILL_DONE = 2'd2
  } fill_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/vram_write_scheduler_if.sv
// CPU write stream channel (decoded register-6 data writes) into the scheduler.
interface vram_write_scheduler_if;
  import vram_write_scheduler_pkg::*;

  logic              cpu_wr_valid;
  logic [ADDR_W-1:0] cpu_wr_addr;
  logic [DATA_W-1:0] cpu_wr_data;
  logic              cpu_wr_ready;

  modport master (output cpu_wr_valid, output cpu_wr_addr, output cpu_wr_data, input cpu_wr_ready);
  modport slave  (input cpu_wr_valid, input cpu_wr_addr, input cpu_wr_data, output cpu_wr_ready);
endinterface

// File: rtl/vram_write_fifo.sv
// Synchronous FIFO for pending CPU writes; no fall-through, push refused while full.
module vram_write_fifo
  import vram_write_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  input  wr_req_t                in_req,
  output logic                   in_ready,
  output logic                   out_valid,
  output wr_req_t                out_req,
  input  logic                   out_pop,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  wr_req_t          mem_q [DEPTH];
  wr_req_t          mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push, pop;

  assign in_ready  = (level_q != LVL_W'(DEPTH));
  assign out_valid = (level_q != '0);
  assign out_req   = mem_q[rd_ptr_q];
  assign level     = level_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_pop && out_valid;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = in_req;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/vram_write_scheduler.sv
// Arbitrates CPU FIFO writes against the fill engine into free renderer slots and
// decodes the granted address onto the tile/attribute/color write ports.
module vram_write_scheduler
  import vram_write_scheduler_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CPU_BURST  = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  vram_write_scheduler_if.slave       cpu,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  input  logic                        fill_start,
  input  logic [ADDR_W-1:0]           fill_addr,
  input  logic [15:0]                 fill_len,
  input  logic [DATA_W-1:0]           fill_data,
  output logic                        fill_busy,
  output logic                        fill_done,
  input  logic                        mem_slot_free,
  output logic                        tile_we,
  output logic [TILE_AW-1:0]          tile_addr,
  output logic [DATA_W-1:0]           tile_data,
  output logic                        attr_we,
  output logic [ATTR_AW-1:0]          attr_addr,
  output logic [DATA_W-1:0]           attr_data,
  output logic                        color_we,
  output logic [COLOR_AW-1:0]         color_addr,
  output logic [DATA_W-1:0]           color_data
);

  localparam int unsigned BURST_W = $clog2(CPU_BURST + 1);

  fill_state_e         fill_state_q, fill_state_d;
  logic [ADDR_W-1:0]   fill_addr_q, fill_addr_d;
  logic [DATA_W-1:0]   fill_data_q, fill_data_d;
  logic [15:0]         fill_rem_q, fill_rem_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic                tile_we_q, tile_we_d, attr_we_q, attr_we_d, color_we_q, color_we_d;
  logic [TILE_AW-1:0]  tile_addr_q, tile_addr_d;
  logic [ATTR_AW-1:0]  attr_addr_q, attr_addr_d;
  logic [COLOR_AW-1:0] color_addr_q, color_addr_d;
  logic [DATA_W-1:0]   tile_data_q, tile_data_d, attr_data_q, attr_data_d;
  logic [DATA_W-1:0]   color_data_q, color_data_d;

  logic    fifo_valid, fill_run, fill_grant, cpu_grant;
  wr_req_t fifo_req, gnt_req;

  vram_write_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (cpu.cpu_wr_valid),
    .in_req    ({cpu.cpu_wr_addr, cpu.cpu_wr_data}),
    .in_ready  (cpu.cpu_wr_ready),
    .out_valid (fifo_valid),
    .out_req   (fifo_req),
    .out_pop   (cpu_grant),
    .level     (fifo_level)
  );

  // Fill preempts the CPU only after CPU_BURST back-to-back CPU grants.
  assign fill_run   = (fill_state_q == FILL_RUN);
  assign fill_grant = mem_slot_free && fill_run &&
                      ((burst_q == BURST_W'(CPU_BURST)) || !fifo_valid);
  assign cpu_grant  = mem_slot_free && fifo_valid && !fill_grant;
  assign gnt_req    = fill_grant ? {fill_addr_q, fill_data_q} : fifo_req;

  always_comb begin
    fill_state_d = fill_state_q;
    fill_addr_d  = fill_addr_q;
    fill_data_d  = fill_data_q;
    fill_rem_d   = fill_rem_q;
    burst_d      = burst_q;
    tile_we_d    = 1'b0;
    attr_we_d    = 1'b0;
    color_we_d   = 1'b0;
    tile_addr_d  = tile_addr_q;
    attr_addr_d  = attr_addr_q;
    color_addr_d = color_addr_q;
    tile_data_d  = tile_data_q;
    attr_data_d  = attr_data_q;
    color_data_d = color_data_q;

    unique case (fill_state_q)
      FILL_IDLE: begin
        if (fill_start) begin
          fill_addr_d  = fill_addr;
          fill_data_d  = fill_data;
          fill_rem_d   = fill_len;
          fill_state_d = (fill_len == 16'd0) ? FILL_DONE : FILL_RUN;
        end
      end
      FILL_RUN: begin
        if (fill_grant) begin
          fill_addr_d = fill_addr_q + ADDR_W'(1);
          fill_rem_d  = fill_rem_q - 16'd1;
          if (fill_rem_q == 16'd1) fill_state_d = FILL_DONE;
        end
      end
      FILL_DONE: fill_state_d = FILL_IDLE;
      default:   fill_state_d = FILL_IDLE;
    endcase

    if (!fill_run || fill_grant) begin
      burst_d = '0;
    end else if (cpu_grant) begin
      burst_d = burst_q + BURST_W'(1);
    end

    // Address decode of whichever request won the slot.
    if (fill_grant || cpu_grant) begin
      if (gnt_req.addr < ATTR_BASE) begin
        tile_we_d   = 1'b1;
        tile_addr_d = gnt_req.addr[TILE_AW-1:0];
        tile_data_d = gnt_req.data;
      end else if (gnt_req.addr < COLOR_BASE) begin
        attr_we_d   = 1'b1;
        attr_addr_d = ATTR_AW'(gnt_req.addr - ATTR_BASE);
        attr_data_d = gnt_req.data;
      end else begin
        color_we_d   = 1'b1;
        color_addr_d = gnt_req.addr[COLOR_AW-1:0];
        color_data_d = gnt_req.data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_state_q <= FILL_IDLE;
      fill_addr_q  <= '0;
      fill_data_q  <= '0;
      fill_rem_q   <= '0;
      burst_q      <= '0;
      tile_we_q    <= 1'b0;
      attr_we_q    <= 1'b0;
      color_we_q   <= 1'b0;
      tile_addr_q  <= '0;
      attr_addr_q  <= '0;
      color_addr_q <= '0;
      tile_data_q  <= '0;
      attr_data_q  <= '0;
      color_data_q <= '0;
    end else begin
      fill_state_q <= fill_state_d;
      fill_addr_q  <= fill_addr_d;
      fill_data_q  <= fill_data_d;
      fill_rem_q   <= fill_rem_d;
      burst_q      <= burst_d;
      tile_we_q    <= tile_we_d;
      attr_we_q    <= attr_we_d;
      color_we_q   <= color_we_d;
      tile_addr_q  <= tile_addr_d;
      attr_addr_q  <= attr_addr_d;
      color_addr_q <= color_addr_d;
      tile_data_q  <= tile_data_d;
      attr_data_q  <= attr_data_d;
      color_data_q <= color_data_d;
    end
  end

  assign fill_busy  = (fill_state_q != FILL_IDLE);
  assign fill_done  = (fill_state_q == FILL_DONE);
  assign tile_we    = tile_we_q;
  assign attr_we    = attr_we_q;
  assign color_we   = color_we_q;
  assign tile_addr  = tile_addr_q;
  assign attr_addr  = attr_addr_q;
  assign color_addr = color_addr_q;
  assign tile_data  = tile_data_q;
  assign attr_data  = attr_data_q;
  assign color_data = color_data_q;

endmodule
